// File: rtl/shift_pkg.sv
// Shared definitions for the sequential shifter: FSM state encoding and
// default operand / shift-count widths.
package shift_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 6;

endpackage

// File: rtl/shift_left.sv
// Sequential logical shifter moving one bit per clock; RIGHT selects direction.
// Optional macro SHIFT_EARLY_EXIT_EN: a shift amount >= DATA_W completes in 2 edges.
module shift_left
  import shift_pkg::*;
#(
  parameter bit RIGHT  = 1'b0,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic [DATA_W-1:0] A,
  input  logic [CNT_W-1:0]  B,
  output logic [DATA_W-1:0] C,
  output logic              busy,
  output logic              done
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] c_q, c_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] acc_step;

  // Single 1-bit step with zero fill; bits shifted out are simply dropped.
  assign acc_step = RIGHT ? (acc_q >> 1) : (acc_q << 1);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = A;
          cnt_d   = B;
          busy_d  = 1'b1;
          state_d = SHIFT;
`ifdef SHIFT_EARLY_EXIT_EN
          // Oversized shifts are known to give zero: go straight to completion.
          if (32'(B) >= 32'(DATA_W)) begin
            acc_d = '0;
            cnt_d = '0;
          end
`endif
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          acc_d = acc_step;
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          c_d     = acc_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      c_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign C    = c_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_shift_left.sv
// Self-checking bench for shift_left: left and right instances share stimulus
// and are compared against a plain-arithmetic shift/latency model.
module tb_shift_left;

  localparam int DW = 32;
  localparam int CW = 6;

  logic          clock = 1'b0;
  logic          resetn;
  logic          start;
  logic [DW-1:0] A;
  logic [CW-1:0] B;
  logic [DW-1:0] c_l, c_r;
  logic          busy_l, done_l, busy_r, done_r;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] prev_l = '0;
  logic [DW-1:0] prev_r = '0;

  always #5 clock = ~clock;

  shift_left #(.RIGHT(1'b0), .DATA_W(DW), .CNT_W(CW)) dut_l (
    .clock(clock), .resetn(resetn), .start(start), .A(A), .B(B),
    .C(c_l), .busy(busy_l), .done(done_l)
  );

  shift_left #(.RIGHT(1'b1), .DATA_W(DW), .CNT_W(CW)) dut_r (
    .clock(clock), .resetn(resetn), .start(start), .A(A), .B(B),
    .C(c_r), .busy(busy_r), .done(done_r)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned latency(input int unsigned b);
`ifdef SHIFT_EARLY_EXIT_EN
    if (b >= DW) return 2;
`endif
    return b + 2;
  endfunction

  // Called #1 after a clock edge with both DUTs idle; returns #1 after the
  // edge that brings them back to IDLE.
  task automatic run_op(input logic [DW-1:0] a, input int unsigned b, input bit keep_start);
    logic [DW-1:0] exp_l, exp_r;
    int unsigned   lat;
    exp_l = (b >= DW) ? '0 : (a << b);
    exp_r = (b >= DW) ? '0 : (a >> b);
    lat   = latency(b);
    A     = a;
    B     = CW'(b);
    start = 1'b1;
    for (int k = 1; k <= int'(lat) + 1; k++) begin
      @(posedge clock);
      #1;
      if (k == 1) begin
        if (keep_start) begin
          A = $urandom;
          B = CW'($urandom);
        end else begin
          start = 1'b0;
        end
      end
      if (k < int'(lat)) begin
        check("busy_l_run", busy_l, 1'b1);
        check("busy_r_run", busy_r, 1'b1);
        check("done_l_run", done_l, 1'b0);
        check("done_r_run", done_r, 1'b0);
        check("c_l_hold", c_l, prev_l);
        check("c_r_hold", c_r, prev_r);
      end else if (k == int'(lat)) begin
        check("busy_l_end", busy_l, 1'b0);
        check("busy_r_end", busy_r, 1'b0);
        check("done_l_end", done_l, 1'b1);
        check("done_r_end", done_r, 1'b1);
        check("c_l_result", c_l, exp_l);
        check("c_r_result", c_r, exp_r);
      end else begin
        check("done_l_pulse", done_l, 1'b0);
        check("done_r_pulse", done_r, 1'b0);
        check("busy_l_idle", busy_l, 1'b0);
        check("c_l_keep", c_l, exp_l);
        check("c_r_keep", c_r, exp_r);
      end
    end
    prev_l = exp_l;
    prev_r = exp_r;
  endtask

  initial begin
    resetn = 1'b0;
    start  = 1'b0;
    A      = '0;
    B      = '0;
    #12;
    check("rst_c_l", c_l, 0);
    check("rst_c_r", c_r, 0);
    check("rst_busy", busy_l | busy_r, 0);
    check("rst_done", done_l | done_r, 0);
    @(posedge clock);
    #1;
    resetn = 1'b1;

    // Directed cases, first launch right after reset release
    run_op(32'd3072, 3, 1'b0);
    run_op(32'h8000_0001, 0, 1'b0);
    run_op(32'h8000_0001, 1, 1'b0);
    run_op(32'hFFFF_FFFF, 40, 1'b0);
    // start held high with changing A/B while busy, then back-to-back launch
    run_op(32'h0000_1234, 5, 1'b1);
    run_op(32'h0000_ABCD, 7, 1'b0);

    // Abort an operation with reset after its second edge
    A     = 32'h0000_F0F0;
    B     = CW'(10);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    @(posedge clock);
    #1;
    resetn = 1'b0;
    #1;
    check("abort_c_l", c_l, 0);
    check("abort_c_r", c_r, 0);
    check("abort_busy", busy_l | busy_r, 0);
    check("abort_done", done_l | done_r, 0);
    prev_l = '0;
    prev_r = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      check("abort_no_done", done_l | done_r, 0);
    end
    resetn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clock);
      #1;
      check("post_abort_quiet", done_l | done_r | busy_l | busy_r, 0);
    end
    run_op(32'h0000_0005, 2, 1'b0);

    // Randomized operations, some oversized, some with start held high
    for (int i = 0; i < 16; i++) begin
      logic [DW-1:0] a;
      int unsigned   b;
      bit            keep;
      a    = $urandom;
      b    = ($urandom_range(0, 3) == 0) ? $urandom_range(32, 63) : $urandom_range(0, 31);
      keep = 1'($urandom_range(0, 1));
      run_op(a, b, keep);
    end
    start = 1'b0;
    @(posedge clock);
    #1;
    check("final_idle", busy_l | busy_r | done_l | done_r, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
